// File: rtl/passcode_lock.sv
// Keypad code-entry controller: buffers digits, checks them against a stored
// passcode, supports reprogramming while unlocked, and locks out after repeated failures.
module passcode_lock #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int                    MAX_TRIES      = 3,
    parameter int                    LOCKOUT_CYCLES = 1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   digit,
    input  logic                         valid,
    output logic                         unlocked,
    output logic                         alarm,
    output logic                         ok,
    output logic                         error,
    output logic [$clog2(CODE_LEN+1)-1:0] entry_count,
    output logic [4*CODE_LEN-1:0]        entry
);
    // state    | meaning
    // LOCKED   | collecting digits, E compares against code
    // UNLOCKED | open; A/E relock, C starts reprogramming
    // PROGRAM  | collecting digits, E stores them as the new code
    // LOCKOUT  | alarm held, all keys ignored until timer expires

    localparam int CW = $clog2(CODE_LEN+1);
    localparam int FW = $clog2(MAX_TRIES+1);
    localparam int TW = $clog2(LOCKOUT_CYCLES+1);

    localparam logic [CW-1:0] FULL       = CW'(CODE_LEN);
    localparam logic [FW-1:0] TRIES_LAST = FW'(MAX_TRIES-1);
    localparam logic [TW-1:0] TIMER_INIT = TW'(LOCKOUT_CYCLES-1);

    localparam logic [3:0] KEY_CLR = 4'hA;
    localparam logic [3:0] KEY_CHG = 4'hC;
    localparam logic [3:0] KEY_ENT = 4'hE;

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_UNLOCKED = 2'd1,
        S_PROGRAM  = 2'd2,
        S_LOCKOUT  = 2'd3
    } state_t;

    state_t                state;
    logic [4*CODE_LEN-1:0] code;
    logic [FW-1:0]         fail_cnt;
    logic [TW-1:0]         timer;
    logic                  overflow;

    logic                  is_digit;
    logic                  accept;
    logic                  buf_push;
    logic                  buf_clear;
    logic                  entry_full;
    logic [4*CODE_LEN+3:0] shifted;

    assign is_digit   = (digit <= 4'd9);
    assign accept     = valid && (state != S_LOCKOUT);
    assign entry_full = (entry_count == FULL) && !overflow;
    assign shifted    = {entry, digit};

    always_comb begin
        buf_push  = 1'b0;
        buf_clear = 1'b0;
        if (accept) begin
            if (is_digit)
                buf_push = (state == S_LOCKED) || (state == S_PROGRAM);
            else if (digit == KEY_CLR || digit == KEY_ENT)
                buf_clear = 1'b1;
            else if (digit == KEY_CHG)
                buf_clear = (state == S_UNLOCKED);
        end
    end

    // Entry buffer: once full, new digits push out the oldest and mark overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry       <= '0;
            entry_count <= '0;
            overflow    <= 1'b0;
        end else if (buf_clear) begin
            entry       <= '0;
            entry_count <= '0;
            overflow    <= 1'b0;
        end else if (buf_push) begin
            entry <= shifted[4*CODE_LEN-1:0];
            if (entry_count == FULL)
                overflow <= 1'b1;
            else
                entry_count <= entry_count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_LOCKED;
            code     <= DEFAULT_CODE;
            fail_cnt <= '0;
            timer    <= '0;
            unlocked <= 1'b0;
            alarm    <= 1'b0;
            ok       <= 1'b0;
            error    <= 1'b0;
        end else begin
            ok    <= 1'b0;
            error <= 1'b0;
            case (state)
                S_LOCKED: begin
                    if (valid && digit == KEY_ENT) begin
                        if (entry_full && entry == code) begin
                            state    <= S_UNLOCKED;
                            unlocked <= 1'b1;
                            fail_cnt <= '0;
                            ok       <= 1'b1;
                        end else begin
                            error <= 1'b1;
                            if (fail_cnt == TRIES_LAST) begin
                                state    <= S_LOCKOUT;
                                alarm    <= 1'b1;
                                timer    <= TIMER_INIT;
                                fail_cnt <= '0;
                            end else begin
                                fail_cnt <= fail_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_UNLOCKED: begin
                    if (valid && (digit == KEY_CLR || digit == KEY_ENT)) begin
                        state    <= S_LOCKED;
                        unlocked <= 1'b0;
                    end else if (valid && digit == KEY_CHG) begin
                        state <= S_PROGRAM;
                    end
                end
                S_PROGRAM: begin
                    if (valid && digit == KEY_ENT) begin
                        if (entry_full) begin
                            code  <= entry;
                            state <= S_UNLOCKED;
                            ok    <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end else if (valid && digit == KEY_CLR) begin
                        state <= S_UNLOCKED;
                    end
                end
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        state <= S_LOCKED;
                        alarm <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= S_LOCKED;
            endcase
        end
    end
endmodule

// File: tb/tb_passcode_lock.sv
// Directed bench for passcode_lock with a shortened lockout (5 cycles).
module tb_passcode_lock;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  digit = 4'h0;
    logic        valid = 1'b0;
    logic        unlocked, alarm, ok, error;
    logic [2:0]  entry_count;
    logic [15:0] entry;

    int n_cmp = 0;
    int n_err = 0;

    passcode_lock #(
        .CODE_LEN(4), .DEFAULT_CODE(16'h1234), .MAX_TRIES(3), .LOCKOUT_CYCLES(5)
    ) dut (
        .clk(clk), .reset(reset), .digit(digit), .valid(valid),
        .unlocked(unlocked), .alarm(alarm), .ok(ok), .error(error),
        .entry_count(entry_count), .entry(entry)
    );

    always #5 clk = ~clk;

    // Called just after a falling edge; returns just after the next falling edge,
    // so outputs reflect the key. Consecutive calls give back-to-back valid.
    task automatic key(input logic [3:0] k);
        digit = k;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic enter4(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) key(c[4*i +: 4]);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if (unlocked !== 1'b0) begin n_err++; $display("FAIL reset_unlocked got=%b exp=0", unlocked); end
        n_cmp++; if (alarm !== 1'b0) begin n_err++; $display("FAIL reset_alarm got=%b exp=0", alarm); end
        n_cmp++; if ({ok, error} !== 2'b00) begin n_err++; $display("FAIL reset_pulses got=%b exp=00", {ok, error}); end
        n_cmp++; if (entry_count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", entry_count); end
        n_cmp++; if (entry !== 16'h0) begin n_err++; $display("FAIL reset_entry got=%h exp=0000", entry); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_correct_code;
        logic [15:0] exp_entry;
        exp_entry = 16'h0;
        for (int i = 1; i <= 4; i++) begin
            key(4'(i));
            exp_entry = {exp_entry[11:0], 4'(i)};
            n_cmp++; if (entry_count !== 3'(i)) begin n_err++; $display("FAIL cc_count%0d got=%0d exp=%0d", i, entry_count, i); end
            n_cmp++; if (entry !== exp_entry) begin n_err++; $display("FAIL cc_entry%0d got=%h exp=%h", i, entry, exp_entry); end
        end
        key(4'hE);
        n_cmp++; if ({ok, error, unlocked} !== 3'b101) begin n_err++; $display("FAIL cc_unlock got=%b exp=101", {ok, error, unlocked}); end
        n_cmp++; if ({entry_count, entry} !== 19'h0) begin n_err++; $display("FAIL cc_cleared got=%0d/%h exp=0/0000", entry_count, entry); end
        @(negedge clk);
        n_cmp++; if ({ok, unlocked} !== 2'b01) begin n_err++; $display("FAIL cc_ok_once got=%b exp=01", {ok, unlocked}); end
        key(4'hE);
        n_cmp++; if ({ok, error, unlocked} !== 3'b000) begin n_err++; $display("FAIL cc_relock got=%b exp=000", {ok, error, unlocked}); end
    endtask

    task automatic test_ignored_keys;
        key(4'h7);
        key(4'hB); key(4'hD); key(4'hF); key(4'hC);
        n_cmp++; if ({entry_count, entry} !== {3'd1, 16'h0007}) begin n_err++; $display("FAIL ign_buffer got=%0d/%h exp=1/0007", entry_count, entry); end
        n_cmp++; if ({ok, error, unlocked, alarm} !== 4'b0000) begin n_err++; $display("FAIL ign_outputs got=%b exp=0000", {ok, error, unlocked, alarm}); end
        key(4'hA);
        n_cmp++; if ({entry_count, entry} !== 19'h0) begin n_err++; $display("FAIL ign_clear got=%0d/%h exp=0/0000", entry_count, entry); end
    endtask

    task automatic test_overflow_lockout;
        int hi;
        for (int i = 1; i <= 5; i++) key(4'(i));
        n_cmp++; if ({entry_count, entry} !== {3'd4, 16'h2345}) begin n_err++; $display("FAIL ov_buffer got=%0d/%h exp=4/2345", entry_count, entry); end
        key(4'hE);
        n_cmp++; if ({error, ok, unlocked, alarm} !== 4'b1000) begin n_err++; $display("FAIL ov_reject got=%b exp=1000", {error, ok, unlocked, alarm}); end
        key(4'h1); key(4'h2); key(4'h3); key(4'hE);
        n_cmp++; if ({error, unlocked, alarm} !== 3'b100) begin n_err++; $display("FAIL short_reject got=%b exp=100", {error, unlocked, alarm}); end
        enter4(16'h9999); key(4'hE);
        n_cmp++; if ({error, alarm, unlocked} !== 3'b110) begin n_err++; $display("FAIL lo_enter got=%b exp=110", {error, alarm, unlocked}); end
        hi = 1;
        for (int i = 1; i <= 4; i++) begin
            key(4'(i));
            if (alarm === 1'b1) hi++;
            n_cmp++; if ({entry_count, ok, error, unlocked} !== 6'b0) begin n_err++; $display("FAIL lo_ignore%0d got=%0d/%b exp=0/000", i, entry_count, {ok, error, unlocked}); end
        end
        key(4'hE);  // lands on the final lockout cycle and must be ignored
        n_cmp++; if ({alarm, ok, error, unlocked} !== 4'b0000) begin n_err++; $display("FAIL lo_exit got=%b exp=0000", {alarm, ok, error, unlocked}); end
        n_cmp++; if (hi !== 5) begin n_err++; $display("FAIL lo_length got=%0d exp=5", hi); end
        enter4(16'h1234); key(4'hE);
        n_cmp++; if ({ok, unlocked} !== 2'b11) begin n_err++; $display("FAIL lo_after_unlock got=%b exp=11", {ok, unlocked}); end
    endtask

    task automatic test_code_change;
        key(4'h5);
        n_cmp++; if (entry_count !== 3'd0) begin n_err++; $display("FAIL chg_unlocked_digit got=%0d exp=0", entry_count); end
        key(4'hC);
        enter4(16'h9876);
        n_cmp++; if ({entry_count, entry, unlocked} !== {3'd4, 16'h9876, 1'b1}) begin n_err++; $display("FAIL chg_buffer got=%0d/%h/%b exp=4/9876/1", entry_count, entry, unlocked); end
        key(4'hE);
        n_cmp++; if ({ok, error, unlocked} !== 3'b101) begin n_err++; $display("FAIL chg_store got=%b exp=101", {ok, error, unlocked}); end
        key(4'hE);
        n_cmp++; if (unlocked !== 1'b0) begin n_err++; $display("FAIL chg_relock got=%b exp=0", unlocked); end
        enter4(16'h1234); key(4'hE);
        n_cmp++; if ({ok, error, unlocked} !== 3'b010) begin n_err++; $display("FAIL chg_old_rejected got=%b exp=010", {ok, error, unlocked}); end
        enter4(16'h9876); key(4'hE);
        n_cmp++; if ({ok, error, unlocked} !== 3'b101) begin n_err++; $display("FAIL chg_new_accepted got=%b exp=101", {ok, error, unlocked}); end
    endtask

    task automatic test_program_abort;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        enter4(16'h1234); key(4'hE);
        n_cmp++; if ({ok, unlocked} !== 2'b11) begin n_err++; $display("FAIL pa_default_restored got=%b exp=11", {ok, unlocked}); end
        key(4'hC); key(4'h5); key(4'h5); key(4'hE);
        n_cmp++; if ({error, ok, unlocked} !== 3'b101) begin n_err++; $display("FAIL pa_short got=%b exp=101", {error, ok, unlocked}); end
        for (int i = 1; i <= 5; i++) key(4'(i));
        key(4'hE);
        n_cmp++; if ({error, ok, entry_count} !== {2'b10, 3'd0}) begin n_err++; $display("FAIL pa_overflow got=%b/%0d exp=10/0", {error, ok}, entry_count); end
        key(4'h5);
        n_cmp++; if (entry_count !== 3'd1) begin n_err++; $display("FAIL pa_still_program got=%0d exp=1", entry_count); end
        key(4'hA);
        key(4'h6);
        n_cmp++; if ({entry_count, unlocked, ok, error} !== {3'd0, 3'b100}) begin n_err++; $display("FAIL pa_abort got=%0d/%b exp=0/100", entry_count, {unlocked, ok, error}); end
        key(4'hA);
        enter4(16'h1234); key(4'hE);
        n_cmp++; if ({ok, unlocked} !== 2'b11) begin n_err++; $display("FAIL pa_code_kept got=%b exp=11", {ok, unlocked}); end
    endtask

    task automatic test_async_reset;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (unlocked !== 1'b0) begin n_err++; $display("FAIL ar_unlocked got=%b exp=0", unlocked); end
        @(negedge clk); reset = 1'b0;
        key(4'h1); key(4'h2);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({entry_count, entry} !== 19'h0) begin n_err++; $display("FAIL ar_mid_entry got=%0d/%h exp=0/0000", entry_count, entry); end
        @(negedge clk); reset = 1'b0;
        for (int t = 0; t < 3; t++) begin enter4(16'h5555); key(4'hE); end
        @(negedge clk);
        n_cmp++; if (alarm !== 1'b1) begin n_err++; $display("FAIL ar_lockout_entered got=%b exp=1", alarm); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({alarm, unlocked, ok, error} !== 4'b0000) begin n_err++; $display("FAIL ar_mid_lockout got=%b exp=0000", {alarm, unlocked, ok, error}); end
        @(negedge clk); reset = 1'b0;
        enter4(16'h1234); key(4'hE);
        n_cmp++; if ({ok, unlocked, alarm} !== 3'b110) begin n_err++; $display("FAIL ar_after_release got=%b exp=110", {ok, unlocked, alarm}); end
    endtask

    initial begin
        test_reset();
        test_correct_code();
        test_ignored_keys();
        test_overflow_lockout();
        test_code_change();
        test_program_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/passcode_lock.md
# passcode_lock

Code-entry controller for the security device. It sits directly downstream of the keypad decoder and consumes that stage's `digit`/`valid` key stream. Digits are collected into an entry buffer, and the E key submits the entry for comparison against a stored passcode. The block drives the lock and alarm status and supports re-programming the passcode while unlocked, with lockout after repeated failures.

## Interface
- `CODE_LEN`, default 4: passcode length in digits (≥1).
- `DEFAULT_CODE`, default 16'h1234: reset passcode, `4*CODE_LEN` bits; the first-entered digit is the most significant nibble.
- `MAX_TRIES`, default 3: consecutive failed submits that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, default 1000: number of cycles the alarm is held (≥1).

Ports:
- `clk`  input  1  clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `digit`  input  4  key code from the decoder (0–9 digits, A=clear, C=change code, E=enter; B/D/F ignored).
- `valid`  input  1  one-cycle strobe; `digit` is sampled only when high.
- `unlocked`  output  1  level, high in UNLOCKED and PROGRAM.
- `alarm`  output  1  level, high in LOCKOUT.
- `ok`  output  1  one-cycle pulse on successful unlock or successful code change.
- `error`  output  1  one-cycle pulse on any rejected submit.
- `entry_count`  output  `$clog2(CODE_LEN+1)`  digits currently buffered, saturating at `CODE_LEN`.
- `entry`  output  `4*CODE_LEN`  buffered digits for display; the newest digit is in `[3:0]`.

## Operation
- **States:** LOCKED, UNLOCKED, PROGRAM, LOCKOUT.
- **Stored registers:** `code` (`4*CODE_LEN`), `fail_cnt` (`$clog2(MAX_TRIES+1)`), `timer` (`$clog2(LOCKOUT_CYCLES+1)`), entry buffer, overflow flag.
- **Digit key (0–9) in LOCKED or PROGRAM:**
  - `entry` shifts left one nibble and the digit enters `[3:0]`.
  - If `entry_count` is already `CODE_LEN`, the oldest digit is dropped and `overflow` is set; the count holds.
  - In UNLOCKED and LOCKOUT, digits are ignored.
- **Clear action:** clears `entry`, `entry_count` and `overflow`.
- **LOCKED:**
  - A performs the clear action. C is ignored.
  - E is a match when `entry_count==CODE_LEN`, `overflow==0` and `entry==code`.
  - On E with a match: go to UNLOCKED, `fail_cnt`←0, pulse `ok`.
  - On E without a match: pulse `error` and increment `fail_cnt`. If the new value equals `MAX_TRIES`, go to LOCKOUT, set `timer`←`LOCKOUT_CYCLES-1` and `fail_cnt`←0.
  - Every E also performs the clear action.
- **UNLOCKED:**
  - A or E relocks: go to LOCKED and perform the clear action.
  - C goes to PROGRAM and performs the clear action.
- **PROGRAM:**
  - E with `entry_count==CODE_LEN` and `overflow==0`: `code`←`entry`, go to UNLOCKED, pulse `ok`.
  - Any other E: pulse `error` and stay in PROGRAM. `fail_cnt` is not affected.
  - A aborts to UNLOCKED with `code` unchanged.
  - Every E or A also performs the clear action.
- **LOCKOUT:**
  - All keys are ignored.
  - Each cycle: if `timer==0`, go to LOCKED; otherwise `timer` decrements.
- **Reset:** state LOCKED, `code`=`DEFAULT_CODE`, and `fail_cnt`, `timer`, buffer, `overflow`, `ok`, `error`, `alarm`, `unlocked` all 0. Reset mid-entry or mid-lockout aborts immediately; a programmed code is lost and reverts to `DEFAULT_CODE`.

## Timing
- All outputs are registered. A key sampled at edge N is reflected in the outputs after edge N: `entry`, `entry_count` and state change, and `ok`/`error` are high for exactly the cycle following edge N.
- Back-to-back `valid` on consecutive cycles must be accepted, with each key processed independently in order.
- `alarm` is high for exactly `LOCKOUT_CYCLES` consecutive cycles, starting the cycle after the failing E edge. `unlocked` stays 0 throughout.
- `valid` arriving on the final LOCKOUT cycle (`timer==0`) is ignored.
- `valid` with `digit` of B, D or F produces no state, buffer or output change.

## Test plan
- **Correct code:** reset, then keys 1,2,3,4,E → `entry_count` steps 1..4, then `ok` pulses once, `unlocked`=1, `entry`=0.
- **Overflow and short entry:** keys 1,2,3,4,5,E → `error` pulse, still LOCKED, `fail_cnt`=1. Then 1,2,3,E → `error` again, `fail_cnt`=2.
- **Lockout:** with `LOCKOUT_CYCLES`=5, wrong code three times → `alarm` high for exactly 5 cycles, and keys 1,2,3,4,E during the alarm are ignored. Afterwards 1,2,3,4,E unlocks.
- **Code change:** unlock, then C,9,8,7,6,E → `ok`, UNLOCKED. Then E (relock), then 1,2,3,4,E → `error`, and 9,8,7,6,E → unlock.
- **Program abort and short program:** in PROGRAM, 5,5,E → `error`, still PROGRAM. Then A → UNLOCKED, with `code` still 16'h1234.
- **Async reset:** assert `reset` between the 2nd and 3rd digits and mid-lockout → all outputs 0 immediately, without waiting for a clock edge. After release, 1,2,3,4,E unlocks.
